// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Bus initiator that copies a block of words inside a single-port memory
// (combinational read, synchronous write). The copy has memmove semantics:
// when the destination lies above the source the block is walked from its
// top word downwards, otherwise from its bottom word upwards, so overlapping
// ranges are never corrupted.
//
// Each word takes two cycles: READ captures mem_rdata into a data register,
// WRITE drives that register onto the destination address with mem_write.
//
// Ports
//   clk           : clock, all state changes on its rising edge
//   rst_n         : asynchronous active-low reset
//   start         : request pulse, only honoured in IDLE
//   src_addr      : first source word, latched on an accepted start
//   dst_addr      : first destination word, latched on an accepted start
//   length        : number of words to copy (0..DEPTH)
//   busy          : engine is not IDLE
//   done          : one-cycle completion pulse
//   error         : last request was rejected (out of range)
//   copied_count  : words written by the current or last transfer
//   mem_write     : memory write enable
//   mem_address   : memory address
//   mem_wdata     : memory write data
//   mem_rdata     : memory read data, valid in the same cycle as mem_address
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] copied_count,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Range checks are done one bit wider than the address so sums cannot wrap.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(0);
  localparam logic [DATA_W-1:0] ZERO_D  = DATA_W'(0);

  state_t              state_r;
  state_t              state_nxt_s;

  logic [ADDR_W-1:0]   src_ptr_r;
  logic [ADDR_W-1:0]   dst_ptr_r;
  logic [ADDR_W-1:0]   len_r;
  logic [ADDR_W-1:0]   count_r;
  logic [DATA_W-1:0]   data_r;
  logic                desc_r;
  logic                error_r;

  logic [ADDR_W:0]     len_ext_s;
  logic [ADDR_W:0]     src_end_s;
  logic [ADDR_W:0]     dst_end_s;
  logic                reject_s;
  logic                zero_len_s;
  logic                descending_s;
  logic                last_word_s;

  // Request qualification: bounds checks, zero length and copy direction.
  always_comb begin
    len_ext_s    = {1'b0, length};
    src_end_s    = {1'b0, src_addr} + len_ext_s;
    dst_end_s    = {1'b0, dst_addr} + len_ext_s;
    reject_s     = (len_ext_s > DEPTH_L) || (src_end_s > DEPTH_L) ||
                   (dst_end_s > DEPTH_L);
    zero_len_s   = (length == ZERO_A);
    descending_s = (dst_addr > src_addr);
    last_word_s  = ((count_r + ONE_A) == len_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (reject_s || zero_len_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: request latch, data capture, pointer stepping and word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr_r <= ZERO_A;
      dst_ptr_r <= ZERO_A;
      len_r     <= ZERO_A;
      count_r   <= ZERO_A;
      data_r    <= ZERO_D;
      desc_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r   <= length;
            count_r <= ZERO_A;
            error_r <= reject_s;
            desc_r  <= descending_s;
            // Pointers are only loaded for requests that will touch memory,
            // so they always stay inside the implemented range.
            if (reject_s || zero_len_s) begin
              src_ptr_r <= ZERO_A;
              dst_ptr_r <= ZERO_A;
            end else if (descending_s) begin
              src_ptr_r <= src_addr + length - ONE_A;
              dst_ptr_r <= dst_addr + length - ONE_A;
            end else begin
              src_ptr_r <= src_addr;
              dst_ptr_r <= dst_addr;
            end
          end
        end
        ST_READ: begin
          data_r <= mem_rdata;
        end
        ST_WRITE: begin
          count_r <= count_r + ONE_A;
          // Skip the step after the final word: a descending copy ending at
          // address 0 would otherwise wrap the pointer.
          if (!last_word_s) begin
            if (desc_r) begin
              src_ptr_r <= src_ptr_r - ONE_A;
              dst_ptr_r <= dst_ptr_r - ONE_A;
            end else begin
              src_ptr_r <= src_ptr_r + ONE_A;
              dst_ptr_r <= dst_ptr_r + ONE_A;
            end
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Memory port and status decode straight from registered state, so a
  // reset removes mem_write in the same instant.
  always_comb begin
    busy         = (state_r != ST_IDLE);
    done         = (state_r == ST_DONE);
    error        = error_r;
    copied_count = count_r;
    mem_write    = 1'b0;
    mem_address  = ZERO_A;
    mem_wdata    = ZERO_D;
    case (state_r)
      ST_READ: begin
        mem_address = src_ptr_r;
      end
      ST_WRITE: begin
        mem_write   = 1'b1;
        mem_address = dst_ptr_r;
        mem_wdata   = data_r;
      end
      default: begin
        mem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Drives mem_copy_engine against a behavioural 16-word memory and compares
// every transfer with a memmove reference computed from a snapshot of the
// memory taken before start.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  src_addr;
  logic [4:0]  dst_addr;
  logic [4:0]  length;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  copied_count;
  logic        mem_write;
  logic [4:0]  mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [16];
  logic [4:0]  wr_q [$];
  int          done_cnt;
  int          n_cmp;
  int          n_err;

  mem_copy_engine #(.ADDR_W(5), .DATA_W(16), .DEPTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .copied_count (copied_count),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port of the memory.
  assign mem_rdata = (mem_address < 5'd16) ? mem[mem_address[3:0]] : 16'd0;

  // Synchronous write port; every write address is logged in order.
  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      wr_q.push_back(mem_address);
      if (mem_address < 5'd16) mem[mem_address[3:0]] <= mem_wdata;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    mem[10] = 16'd10;
    mem[11] = 16'd20;
    mem[12] = 16'd33;
    mem[13] = 16'd89;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},   32'(busy), 32'd0);
    chk({tag, " done"},   32'(done), 32'd0);
    chk({tag, " error"},  32'(error), 32'd0);
    chk({tag, " count"},  32'(copied_count), 32'd0);
    chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, " mem_address"}, 32'(mem_address), 32'd0);
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // One transfer checked against a memmove reference model.
  task automatic run_and_check(input logic [4:0] s, input logic [4:0] d,
                               input logic [4:0] l, input bit mid_pulse,
                               input string tag);
    logic [15:0] snap [16];
    logic [15:0] exp_mem [16];
    logic [15:0] tmp [$];
    bit          exp_err;
    int          exp_lat;
    int          lat;
    int          dc0;
    int          ea;
    for (int i = 0; i < 16; i++) begin
      snap[i]    = mem[i];
      exp_mem[i] = mem[i];
    end
    exp_err = (int'(l) > 16) || (int'(s) + int'(l) > 16) || (int'(d) + int'(l) > 16);
    if (!exp_err) begin
      for (int i = 0; i < int'(l); i++) tmp.push_back(snap[int'(s) + i]);
      for (int i = 0; i < int'(l); i++) exp_mem[int'(d) + i] = tmp[i];
    end
    exp_lat = (exp_err || l == 5'd0) ? 1 : 2 * int'(l) + 1;
    wr_q.delete();
    dc0 = done_cnt;

    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (mid_pulse && lat == 3) begin
        src_addr = 5'd0;
        dst_addr = 5'd5;
        length   = 5'd2;
        start    = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy@done"}, 32'(busy), 32'd1);
    chk({tag, " error"}, 32'(error), 32'(exp_err));
    chk({tag, " count"}, 32'(copied_count), exp_err ? 32'd0 : 32'(l));
    @(negedge clk);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
    chk({tag, " error held"}, 32'(error), 32'(exp_err));
    @(negedge clk);
    @(negedge clk);
    chk({tag, " done pulses"}, 32'(done_cnt - dc0), 32'd1);
    chk({tag, " n writes"}, 32'(wr_q.size()), exp_err ? 32'd0 : 32'(l));
    if (!exp_err) begin
      for (int i = 0; i < int'(l) && i < wr_q.size(); i++) begin
        ea = (d > s) ? int'(d) + int'(l) - 1 - i : int'(d) + i;
        chk({tag, $sformatf(" wr_addr[%0d]", i)}, 32'(wr_q[i]), 32'(ea));
      end
    end
    for (int i = 0; i < 16; i++)
      chk({tag, $sformatf(" mem[%0d]", i)}, 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  initial begin
    logic [15:0] snap2 [4];
    logic [4:0]  rs, rd, rl;
    n_cmp    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = 5'd0;
    dst_addr = 5'd0;
    length   = 5'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    preload();
    run_and_check(5'd10, 5'd0, 5'd4, 1'b0, "plain");
    preload();
    run_and_check(5'd10, 5'd12, 5'd4, 1'b0, "fwd_ovl");
    preload();
    run_and_check(5'd10, 5'd8, 5'd4, 1'b0, "bwd_ovl");
    preload();
    run_and_check(5'd14, 5'd0, 5'd4, 1'b0, "src_oob");
    run_and_check(5'd0, 5'd13, 5'd4, 1'b0, "dst_oob");
    run_and_check(5'd0, 5'd0, 5'd17, 1'b0, "len_oob");
    run_and_check(5'd3, 5'd7, 5'd0, 1'b0, "zero_len");
    run_and_check(5'd0, 5'd0, 5'd16, 1'b0, "full_same");
    preload();
    run_and_check(5'd10, 5'd0, 5'd4, 1'b1, "start_busy");

    // Reset right after the second write of a four-word copy.
    preload();
    for (int i = 0; i < 4; i++) snap2[i] = mem[i];
    wr_q.delete();
    src_addr = 5'd10;
    dst_addr = 5'd0;
    length   = 5'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    chk("mid_reset mem0", 32'(mem[0]), 32'd10);
    chk("mid_reset mem1", 32'(mem[1]), 32'd20);
    chk("mid_reset mem2", 32'(mem[2]), 32'(snap2[2]));
    chk("mid_reset mem3", 32'(mem[3]), 32'(snap2[3]));
    repeat (3) @(negedge clk);
    chk("mid_reset writes", 32'(wr_q.size()), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised transfers, mostly legal with some arbitrary requests.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      if (it % 4 == 3) begin
        rs = 5'($urandom);
        rd = 5'($urandom);
        rl = 5'($urandom_range(0, 18));
      end else begin
        rl = 5'($urandom_range(0, 16));
        rs = 5'($urandom_range(0, 16 - int'(rl)));
        rd = 5'($urandom_range(0, 16 - int'(rl)));
      end
      run_and_check(rs, rd, rl, 1'b0, $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
